// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command sequencer for univ_shift.
// Accepts a command over valid/ready, then drives the register with one load
// cycle, the requested number of shift cycles, and a one-cycle done pulse.
module shift_seq_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [N-1:0]     cmd_data,
    input  logic             abort,
    output logic [1:0]       sr_control,
    output logic [N-1:0]     sr_data_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shifts_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] CTRL_HOLD  = 2'b00;
    localparam logic [1:0] CTRL_LEFT  = 2'b01;
    localparam logic [1:0] CTRL_RIGHT = 2'b10;
    localparam logic [1:0] CTRL_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);

    state_t           state_q, state_d;
    logic             dir_q;
    logic [CNT_W-1:0] left_q, left_d;
    logic [N-1:0]     data_q;
    logic             accept;
    logic [CNT_W-1:0] count_clamped;

    // Saturate the requested count at the register width.
    always_comb begin
        count_clamped = (cmd_count > CNT_MAX) ? CNT_MAX : cmd_count;
    end

    // Next-state and output decode from registered state, captured dir and abort.
    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        sr_control = CTRL_HOLD;
        case (state_q)
            IDLE: begin
                cmd_ready = !abort;
                if (cmd_valid && !abort) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                    left_d  = count_clamped;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    left_d  = '0;
                end else begin
                    sr_control = CTRL_LOAD;
                    state_d    = (left_q == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    left_d  = '0;
                end else begin
                    sr_control = dir_q ? CTRL_RIGHT : CTRL_LEFT;
                    left_d     = left_q - 1'b1;
                    if (left_q <= CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                left_d  = '0;
            end
        endcase
    end

    // State, remaining-shift counter and captured command fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            left_q  <= '0;
            dir_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            if (accept) begin
                dir_q  <= cmd_dir;
                data_q <= cmd_data;
            end
        end
    end

    assign sr_data_in  = data_q;
    assign shifts_left = left_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed self-checking bench for shift_seq_ctrl, with a
// behavioural univ_shift model (zero fill) driven by the controller outputs.
module tb_shift_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [2:0] cmd_count;
    logic [3:0] cmd_data;
    logic       abort;
    logic [1:0] sr_control;
    logic [3:0] sr_data_in;
    logic       busy;
    logic       done;
    logic [2:0] shifts_left;

    int checks = 0;
    int fails  = 0;

    logic [1:0] ctrl_s;
    logic [3:0] data_s;
    logic [3:0] model_q;

    shift_seq_ctrl #(.N(4), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_count  (cmd_count),
        .cmd_data   (cmd_data),
        .abort      (abort),
        .sr_control (sr_control),
        .sr_data_in (sr_data_in),
        .busy       (busy),
        .done       (done),
        .shifts_left(shifts_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample controller outputs just before each rising edge.
    always @(negedge clk) begin
        #4;
        ctrl_s = sr_control;
        data_s = sr_data_in;
    end

    // Downstream shift register model.
    always @(posedge clk) begin
        if (reset) begin
            case (ctrl_s)
                2'b01:   model_q <= {model_q[2:0], 1'b0};
                2'b10:   model_q <= {1'b0, model_q[3:1]};
                2'b11:   model_q <= data_s;
                default: model_q <= model_q;
            endcase
        end
    end

    task automatic test_reset;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (sr_control !== 2'b00) begin fails++; $display("FAIL reset_ctrl got %b exp 00", sr_control); end
        checks++; if (shifts_left !== 3'd0) begin fails++; $display("FAIL reset_left got %0d exp 0", shifts_left); end
        checks++; if (sr_data_in !== 4'b0000) begin fails++; $display("FAIL reset_data got %b exp 0000", sr_data_in); end
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
        cmd_valid = 1'b1;
        cmd_count = 3'd2;
        cmd_data  = 4'b1111;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_hold_busy got %b exp 0", busy); end
        cmd_valid = 1'b0;
        reset     = 1'b1;
        model_q   = 4'b0000;
    endtask

    task automatic test_left_count2;
        logic [1:0] ec;
        logic [2:0] el;
        logic       ed, eb;
        logic [3:0] em;
        int         nbusy;
        @(negedge clk);
        cmd_dir = 1'b0; cmd_count = 3'd2; cmd_data = 4'b1101; cmd_valid = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL l2_ready got %b exp 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_count = 3'd5; cmd_data = 4'b0000; cmd_dir = 1'b1;
        nbusy = busy ? 1 : 0;
        checks++; if (sr_control !== 2'b11) begin fails++; $display("FAIL l2_c1_ctrl got %b exp 11", sr_control); end
        checks++; if (shifts_left !== 3'd2) begin fails++; $display("FAIL l2_c1_left got %0d exp 2", shifts_left); end
        checks++; if (sr_data_in !== 4'b1101) begin fails++; $display("FAIL l2_c1_data got %b exp 1101", sr_data_in); end
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            case (c)
                2:       begin ec = 2'b01; el = 3'd2; ed = 1'b0; eb = 1'b1; em = 4'b1101; end
                3:       begin ec = 2'b01; el = 3'd1; ed = 1'b0; eb = 1'b1; em = 4'b1010; end
                4:       begin ec = 2'b00; el = 3'd0; ed = 1'b1; eb = 1'b1; em = 4'b0100; end
                default: begin ec = 2'b00; el = 3'd0; ed = 1'b0; eb = 1'b0; em = 4'b0100; end
            endcase
            if (busy) nbusy++;
            checks++; if (sr_control !== ec) begin fails++; $display("FAIL l2_c%0d_ctrl got %b exp %b", c, sr_control, ec); end
            checks++; if (shifts_left !== el) begin fails++; $display("FAIL l2_c%0d_left got %0d exp %0d", c, shifts_left, el); end
            checks++; if (done !== ed) begin fails++; $display("FAIL l2_c%0d_done got %b exp %b", c, done, ed); end
            checks++; if (busy !== eb) begin fails++; $display("FAIL l2_c%0d_busy got %b exp %b", c, busy, eb); end
            checks++; if (model_q !== em) begin fails++; $display("FAIL l2_c%0d_reg got %b exp %b", c, model_q, em); end
        end
        checks++; if (nbusy != 4) begin fails++; $display("FAIL l2_busy_cycles got %0d exp 4", nbusy); end
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL l2_ready_after got %b exp 1", cmd_ready); end
        checks++; if (sr_data_in !== 4'b1101) begin fails++; $display("FAIL l2_data_kept got %b exp 1101", sr_data_in); end
    endtask

    task automatic test_right_count0;
        @(negedge clk);
        cmd_dir = 1'b1; cmd_count = 3'd0; cmd_data = 4'b1011; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (sr_control !== 2'b11) begin fails++; $display("FAIL r0_c1_ctrl got %b exp 11", sr_control); end
        checks++; if (shifts_left !== 3'd0) begin fails++; $display("FAIL r0_c1_left got %0d exp 0", shifts_left); end
        @(negedge clk);
        checks++; if (sr_control !== 2'b00) begin fails++; $display("FAIL r0_c2_ctrl got %b exp 00", sr_control); end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL r0_c2_done got %b exp 1", done); end
        checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL r0_c2_ready got %b exp 0", cmd_ready); end
        checks++; if (model_q !== 4'b1011) begin fails++; $display("FAIL r0_c2_reg got %b exp 1011", model_q); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL r0_c3_done got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL r0_c3_busy got %b exp 0", busy); end
        checks++; if (model_q !== 4'b1011) begin fails++; $display("FAIL r0_c3_reg got %b exp 1011", model_q); end
    endtask

    task automatic test_clamp;
        int nright;
        int done_cyc;
        nright   = 0;
        done_cyc = -1;
        @(negedge clk);
        cmd_dir = 1'b1; cmd_count = 3'd7; cmd_data = 4'b1000; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (shifts_left !== 3'd4) begin fails++; $display("FAIL clamp_left got %0d exp 4", shifts_left); end
        checks++; if (sr_control !== 2'b11) begin fails++; $display("FAIL clamp_c1_ctrl got %b exp 11", sr_control); end
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            if (sr_control == 2'b10) nright++;
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        checks++; if (nright != 4) begin fails++; $display("FAIL clamp_shifts got %0d exp 4", nright); end
        checks++; if (done_cyc != 6) begin fails++; $display("FAIL clamp_done_cycle got %0d exp 6", done_cyc); end
        checks++; if (model_q !== 4'b0000) begin fails++; $display("FAIL clamp_reg got %b exp 0000", model_q); end
    endtask

    task automatic test_abort;
        @(negedge clk);
        cmd_dir = 1'b0; cmd_count = 3'd3; cmd_data = 4'b0111; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (sr_control !== 2'b01) begin fails++; $display("FAIL ab_s1_ctrl got %b exp 01", sr_control); end
        checks++; if (shifts_left !== 3'd3) begin fails++; $display("FAIL ab_s1_left got %0d exp 3", shifts_left); end
        @(negedge clk);
        checks++; if (shifts_left !== 3'd2) begin fails++; $display("FAIL ab_s2_left got %0d exp 2", shifts_left); end
        abort = 1'b1;
        #1;
        checks++; if (sr_control !== 2'b00) begin fails++; $display("FAIL ab_forced_ctrl got %b exp 00", sr_control); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL ab_done got %b exp 0", done); end
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ab_idle_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL ab_idle_done got %b exp 0", done); end
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL ab_idle_ready got %b exp 1", cmd_ready); end
        checks++; if (shifts_left !== 3'd0) begin fails++; $display("FAIL ab_idle_left got %0d exp 0", shifts_left); end
        checks++; if (model_q !== 4'b1110) begin fails++; $display("FAIL ab_reg got %b exp 1110", model_q); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0) begin fails++; $display("FAIL ab_late_done got %b exp 0", done); end
        end
        // Abort in IDLE blocks acceptance.
        cmd_valid = 1'b1; cmd_count = 3'd1; abort = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL ab_idle_block_ready got %b exp 0", cmd_ready); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ab_idle_block_busy got %b exp 0", busy); end
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic test_back_to_back;
        int acc0, acc1;
        acc0 = -1;
        acc1 = -1;
        @(negedge clk);
        cmd_dir = 1'b0; cmd_count = 3'd1; cmd_data = 4'b0001; cmd_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) begin
                checks++; if (shifts_left !== 3'd1) begin fails++; $display("FAIL b2b_c1_left got %0d exp 1", shifts_left); end
                checks++; if (sr_data_in !== 4'b0001) begin fails++; $display("FAIL b2b_c1_data got %b exp 0001", sr_data_in); end
                cmd_count = 3'd2;
                cmd_data  = 4'b0110;
            end
            if (acc1 >= 0 && k == acc1 + 1) begin
                checks++; if (sr_control !== 2'b11) begin fails++; $display("FAIL b2b_c2_ctrl got %b exp 11", sr_control); end
                checks++; if (shifts_left !== 3'd2) begin fails++; $display("FAIL b2b_c2_left got %0d exp 2", shifts_left); end
                checks++; if (sr_data_in !== 4'b0110) begin fails++; $display("FAIL b2b_c2_data got %b exp 0110", sr_data_in); end
                cmd_valid = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                if (acc0 < 0) acc0 = k;
                else if (acc1 < 0) acc1 = k;
            end
        end
        cmd_valid = 1'b0;
        checks++; if (acc0 != 0) begin fails++; $display("FAIL b2b_first_accept got %0d exp 0", acc0); end
        checks++; if (acc1 - acc0 != 4) begin fails++; $display("FAIL b2b_spacing got %0d exp 4", acc1 - acc0); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        cmd_dir = 1'b0; cmd_count = 3'd4; cmd_data = 4'b1001; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (shifts_left !== 3'd3) begin fails++; $display("FAIL rm_pre_left got %0d exp 3", shifts_left); end
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy got %b exp 0", busy); end
        checks++; if (sr_control !== 2'b00) begin fails++; $display("FAIL rm_ctrl got %b exp 00", sr_control); end
        checks++; if (shifts_left !== 3'd0) begin fails++; $display("FAIL rm_left got %0d exp 0", shifts_left); end
        checks++; if (sr_data_in !== 4'b0000) begin fails++; $display("FAIL rm_data got %b exp 0000", sr_data_in); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL rm_done got %b exp 0", done); end
        @(negedge clk);
        reset = 1'b1;
        cmd_dir = 1'b1; cmd_count = 3'd1; cmd_data = 4'b0011; cmd_valid = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rm_ready got %b exp 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rm_new_busy got %b exp 1", busy); end
        checks++; if (sr_control !== 2'b11) begin fails++; $display("FAIL rm_new_ctrl got %b exp 11", sr_control); end
        checks++; if (sr_data_in !== 4'b0011) begin fails++; $display("FAIL rm_new_data got %b exp 0011", sr_data_in); end
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_timeout busy got %b exp 0", busy); end
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_count = 3'd0;
        cmd_data  = 4'b0000;
        abort     = 1'b0;
        model_q   = 4'b0000;
        ctrl_s    = 2'b00;
        data_s    = 4'b0000;
        test_reset();
        test_left_count2();
        test_right_count0();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
